serial_operand_feeder: RTL and testbench

Upstream stage for the bit-serial adder. It accepts parallel operand pairs (In1, In2) over a valid/ready handshake and buffers them in a small FIFO. It then streams each pair LSB-first, one bit pair per clock, with frame markers so the adder can clear its carry at frame start and capture Sbit at frame end. Back-pressure from the adder side stalls the stream without losing bits.

---
 rtl/serial_operand_feeder.sv | 125 ++++++++++++
 tb/tb_serial_operand_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - buffers operand pairs and streams them LSB-first, one bit pair per clock, with frame markers.
// Optional SERIAL_GUARD_BIT_EN appends a zero guard bit to every frame.
module serial_operand_feeder #(
    parameter int DWL   = 4,
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           InValid,
    output logic           InReady,
    input  logic [DWL-1:0] In1,
    input  logic [DWL-1:0] In2,
    input  logic           BitReady,
    output logic           BitValid,
    output logic           BitA,
    output logic           BitB,
    output logic           FirstBit,
    output logic           LastBit,
    output logic           Busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef SERIAL_GUARD_BIT_EN
    localparam int FRAME_LEN = DWL + 1;
`else
    localparam int FRAME_LEN = DWL;
`endif
    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_CNT = BW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state, state_n;
    logic [DWL-1:0] mem_a [DEPTH];
    logic [DWL-1:0] mem_b [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [DWL-1:0] sh_a, sh_b;
    logic [BW-1:0]  bit_cnt;
    logic           push, pop, load, shift, last;

    assign InReady  = (count != FULL);
    assign BitValid = (state == SHIFT);
    assign last     = (bit_cnt == LAST_CNT);
    assign BitA     = BitValid && sh_a[0];
    assign BitB     = BitValid && sh_b[0];
    assign FirstBit = BitValid && (bit_cnt == '0);
    assign LastBit  = BitValid && last;
    assign Busy     = BitValid || (count != '0);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        push    = InValid && InReady;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (BitReady) begin
                    if (!last) begin
                        shift = 1'b1;
                    end else if (count != '0) begin
                        // Back-to-back frames: reload on the last bit so no bubble appears.
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load) begin
                sh_a    <= mem_a[rd_ptr];
                sh_b    <= mem_b[rd_ptr];
                bit_cnt <= '0;
            end else if (shift) begin
                // Zero fill also supplies the guard bit when that frame extension is enabled.
                sh_a    <= {1'b0, sh_a[DWL-1:1]};
                sh_b    <= {1'b0, sh_b[DWL-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr] <= In1;
            mem_b[wr_ptr] <= In2;
        end
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - scoreboard bench for serial_operand_feeder.
module tb_serial_operand_feeder;

    localparam int DWL   = 4;
    localparam int DEPTH = 2;
`ifdef SERIAL_GUARD_BIT_EN
    localparam int FL = DWL + 1;
`else
    localparam int FL = DWL;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           InValid = 1'b0;
    logic           BitReady = 1'b0;
    logic [DWL-1:0] In1 = '0;
    logic [DWL-1:0] In2 = '0;
    logic           InReady, BitValid, BitA, BitB, FirstBit, LastBit, Busy;

    logic [3:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    bit         rand_ready = 1'b0;
    int         cyc = 0;
    int         first_v = -1;
    int         last_v = -1;
    int         nvalid = 0;

    serial_operand_feeder #(.DWL(DWL), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady),
        .In1(In1), .In2(In2), .BitReady(BitReady), .BitValid(BitValid),
        .BitA(BitA), .BitB(BitB), .FirstBit(FirstBit), .LastBit(LastBit),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: an accepted pair becomes FL entries {a, b, first, last}, LSB first, zeros past DWL.
    task automatic model_push(input logic [DWL-1:0] a, input logic [DWL-1:0] b);
        logic [DWL-1:0] la, lb;
        la = a;
        lb = b;
        for (int i = 0; i < FL; i++) begin
            exp_q.push_back({la[0], lb[0], i == 0, i == FL - 1});
            la = la >> 1;
            lb = lb >> 1;
        end
    endtask

    task automatic push_pair(input logic [DWL-1:0] a, input logic [DWL-1:0] b);
        int n = 0;
        InValid = 1'b1;
        In1 = a;
        In2 = b;
        @(negedge CLK);
        while (!InReady && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!InReady) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got InReady=0 expected 1 within 200 cycles");
        end else begin
            model_push(a, b);
        end
        @(posedge CLK);
        #1;
        InValid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || Busy) && n < 5000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, {exp_q.size() == 0, Busy}, 2'b10);
    endtask

    task automatic clear_span();
        first_v = -1;
        last_v = -1;
        nvalid = 0;
    endtask

    // Monitor: compares the presented bit against the scoreboard head, pops on transfer.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST && BitValid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                nvalid++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit: got BitValid=1 expected no pending bits");
                end else begin
                    check("bit_stream", {BitA, BitB, FirstBit, LastBit}, exp_q[0]);
                    if (BitReady) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_ready) BitReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [DWL-1:0] ra, rb;
        int n;

        BitReady = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", {BitValid, BitA, BitB, FirstBit, LastBit, Busy, InReady}, 7'b0000001);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_reset", {BitValid, Busy, InReady}, 3'b001);

        // Single pair and first-bit latency
        push_pair(4'b1110, 4'b0111);
        check("latency_idle", BitValid, 1'b0);
        @(posedge CLK);
        #1;
        check("latency_first", {BitValid, FirstBit}, 2'b11);
        wait_drain("single_drain");

        // Back-to-back frames are contiguous
        clear_span();
        push_pair(4'b0000, 4'b0000);
        push_pair(4'b1111, 4'b1111);
        push_pair(4'b1010, 4'b0101);
        wait_drain("b2b_drain");
        check("b2b_count", nvalid, 3 * FL);
        check("b2b_contig", last_v - first_v + 1, 3 * FL);

        // Back-pressure until full
        BitReady = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push_pair(4'($urandom), 4'($urandom));
        check("full_ready", {InReady, BitValid, Busy}, 3'b011);
        repeat (5) @(posedge CLK);
        #1;
        check("full_hold", {InReady, BitValid, FirstBit}, 3'b011);
        BitReady = 1'b1;
        wait_drain("full_drain");

        // Push on the edge where the last bit transfers while one pair is buffered
        clear_span();
        push_pair(4'b0011, 4'b1100);
        push_pair(4'b0101, 4'b1001);
        n = 0;
        while (!(BitValid && LastBit) && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("sim_reach_last", {BitValid, LastBit}, 2'b11);
        push_pair(4'b1111, 4'b0001);
        check("sim_no_bubble", {BitValid, FirstBit}, 2'b11);
        check("sim_count_kept", InReady, 1'b1);
        wait_drain("sim_drain");
        check("sim_contig", last_v - first_v + 1, 3 * FL);

        // Randomised traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            push_pair(ra, rb);
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
        end
        rand_ready = 1'b0;
        BitReady = 1'b1;
        wait_drain("random_drain");

        // Asynchronous reset mid-frame
        push_pair(4'b1001, 4'b0110);
        push_pair(4'b0111, 4'b1011);
        push_pair(4'b1100, 4'b0011);
        @(posedge CLK);
        #1;
        check("pre_reset_active", BitValid, 1'b1);
        #1;
        RST = 1'b0;
        #1;
        check("async_reset_drop", {BitValid, FirstBit, LastBit, Busy, InReady}, 5'b00001);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_flushed", {BitValid, Busy, InReady}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
